// File: rtl/lcd_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing the LCD_control byte interface between two frame sources.
// Optional stall watchdog enabled by `define LCD_ARB_TIMEOUT_EN.
module lcd_frame_arbiter #(
  parameter int unsigned FRAME_BYTES    = 1024,
  parameter int unsigned CNT_W          = 11,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [7:0] src0_data,
  input  logic       src0_valid,
  input  logic [7:0] src1_data,
  input  logic       src1_valid,
  input  logic       lcd_en_tran,
  output logic       src0_en,
  output logic       src1_en,
  output logic [7:0] lcd_data,
  output logic       lcd_valid,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       frame_done,
  output logic       err_timeout
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if ((FRAME_BYTES == 0) || ((64'(1) << CNT_W) <= 64'(FRAME_BYTES)) ||
      (GAP_CYCLES == 0) || (TIMEOUT_CYCLES == 0)) begin : g_param_err
    $error("lcd_frame_arbiter: invalid parameter set");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             rr_last_q, rr_last_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_valid_q, lcd_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             pick1;
  logic [7:0]       sel_data;
  logic             sel_valid;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               err_timeout_q, err_timeout_d;
`endif

  // Only the granted source is forwarded; the other is ignored entirely.
  assign sel_data  = gnt_q[1] ? src1_data  : src0_data;
  assign sel_valid = gnt_q[1] ? src1_valid : src0_valid;
  assign pick1     = req[1] & (~req[0] | ~rr_last_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 2'b00;
      rr_last_q    <= 1'b1;
      byte_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      lcd_data_q   <= 8'h00;
      lcd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
      stall_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_last_q    <= rr_last_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      lcd_data_q   <= lcd_data_d;
      lcd_valid_q  <= lcd_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef LCD_ARB_TIMEOUT_EN
      stall_cnt_q   <= stall_cnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_last_d    = rr_last_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    lcd_data_d   = 8'h00;
    lcd_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
    stall_cnt_d   = '0;
    err_timeout_d = err_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_d    = ST_GRANT;
          gnt_d      = pick1 ? 2'b10 : 2'b01;
          rr_last_d  = pick1;
          byte_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        lcd_data_d  = sel_data;
        lcd_valid_d = sel_valid;
        if (sel_valid) begin
          if (byte_cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
            byte_cnt_d   = '0;
            gnt_d        = 2'b00;
            frame_done_d = 1'b1;
            gap_cnt_d    = '0;
            state_d      = ST_GAP;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
`ifdef LCD_ARB_TIMEOUT_EN
        // Stalled too long: abandon the frame without a frame_done pulse.
        else if (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
          byte_cnt_d    = '0;
          gnt_d         = 2'b00;
          gap_cnt_d     = '0;
          err_timeout_d = 1'b1;
          state_d       = ST_GAP;
        end else begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign src0_en    = lcd_en_tran & gnt_q[0];
  assign src1_en    = lcd_en_tran & gnt_q[1];
  assign lcd_data   = lcd_data_q;
  assign lcd_valid  = lcd_valid_q;
  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
`ifdef LCD_ARB_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Directed self-checking bench for lcd_frame_arbiter (FRAME_BYTES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=8).
module tb_lcd_frame_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] src0_data, src1_data;
  logic       src0_valid, src1_valid, lcd_en_tran;
  logic       src0_en, src1_en, lcd_valid, busy, frame_done, err_timeout;
  logic [7:0] lcd_data;
  logic [1:0] gnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_g, prev_g;
  logic [7:0] s1_bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic       s4_v     [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] s4_d     [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

  always #5 clk = ~clk;

  lcd_frame_arbiter #(
    .FRAME_BYTES(4), .CNT_W(3), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .src0_data(src0_data), .src0_valid(src0_valid),
    .src1_data(src1_data), .src1_valid(src1_valid),
    .lcd_en_tran(lcd_en_tran), .src0_en(src0_en), .src1_en(src1_en),
    .lcd_data(lcd_data), .lcd_valid(lcd_valid), .gnt(gnt), .busy(busy),
    .frame_done(frame_done), .err_timeout(err_timeout)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 2'b00; src0_valid = 1'b0; src1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; src0_data = 8'h00; src1_data = 8'h00;
    src0_valid = 1'b0; src1_valid = 1'b0; lcd_en_tran = 1'b1;
    tick(); tick();
    check("rst_gnt", 16'(gnt), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_valid", 16'(lcd_valid), 16'h0);
    check("rst_data", 16'(lcd_data), 16'h0);
    check("rst_done", 16'(frame_done), 16'h0);
    check("rst_err", 16'(err_timeout), 16'h0);
    check("rst_en0", 16'(src0_en), 16'h0);

    // single frame from src0
    rst_n = 1'b1; req = 2'b01;
    tick();
    check("s1_gnt", 16'(gnt), 16'h1);
    check("s1_busy", 16'(busy), 16'h1);
    check("s1_en0", 16'(src0_en), 16'h1);
    check("s1_en1", 16'(src1_en), 16'h0);
    for (int k = 0; k < 4; k++) begin
      src0_valid = 1'b1; src0_data = s1_bytes[k];
      tick();
      check("s1_data", 16'(lcd_data), 16'(s1_bytes[k]));
      check("s1_valid", 16'(lcd_valid), 16'h1);
      check("s1_done", 16'(frame_done), 16'(k == 3));
      check("s1_gnt_run", 16'(gnt), (k == 3) ? 16'h0 : 16'h1);
    end
    src0_valid = 1'b0; req = 2'b00;
    tick();
    check("s1_gap_busy", 16'(busy), 16'h1);
    check("s1_gap_valid", 16'(lcd_valid), 16'h0);
    check("s1_gap_done", 16'(frame_done), 16'h0);
    tick();
    check("s1_idle_busy", 16'(busy), 16'h0);

    // both request continuously: round-robin with fixed gap
    do_reset();
    req = 2'b11; src0_valid = 1'b1; src1_valid = 1'b1;
    src0_data = 8'hA1; src1_data = 8'h5E; prev_g = 2'b00;
    for (int i = 0; i < 21; i++) begin
      tick();
      exp_g = (i % 7 < 4) ? (((i / 7) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check("s2_gnt", 16'(gnt), 16'(exp_g));
      check("s2_valid", 16'(lcd_valid), 16'(prev_g != 2'b00));
      if (prev_g != 2'b00)
        check("s2_data", 16'(lcd_data), (prev_g == 2'b01) ? 16'h00A1 : 16'h005E);
      check("s2_done", 16'(frame_done), 16'(i % 7 == 4));
      prev_g = exp_g;
    end

    // req dropped mid-frame; frame completes, src1 then granted
    do_reset();
    req = 2'b01;
    tick();
    src0_valid = 1'b1; src0_data = 8'h11;
    tick();
    req = 2'b10;
    for (int k = 0; k < 3; k++) begin
      src0_data = 8'(8'h22 + 8'(k * 17));
      tick();
      check("s3_data", 16'(lcd_data), 16'(8'h22 + 8'(k * 17)));
      check("s3_gnt", 16'(gnt), (k == 2) ? 16'h0 : 16'h1);
      check("s3_done", 16'(frame_done), 16'(k == 2));
    end
    src0_valid = 1'b0;
    tick();
    check("s3_gap0", 16'(gnt), 16'h0);
    tick();
    check("s3_gap1", 16'(gnt), 16'h0);
    tick();
    check("s3_gnt1", 16'(gnt), 16'h2);

    // src1 activity while src0 owns the LCD
    do_reset();
    req = 2'b01;
    tick();
    lcd_en_tran = 1'b0; #1;
    check("s4_en0_gated", 16'(src0_en), 16'h0);
    lcd_en_tran = 1'b1; #1;
    check("s4_en0_open", 16'(src0_en), 16'h1);
    src1_data = 8'hEE;
    for (int k = 0; k < 5; k++) begin
      src0_valid = s4_v[k]; src0_data = s4_d[k]; src1_valid = (k % 2 == 0);
      tick();
      check("s4_valid", 16'(lcd_valid), 16'(s4_v[k]));
      if (s4_v[k]) check("s4_data", 16'(lcd_data), 16'(s4_d[k]));
      check("s4_en1", 16'(src1_en), 16'h0);
      check("s4_en0", 16'(src0_en), 16'(k < 4));
      check("s4_done", 16'(frame_done), 16'(k == 4));
    end
    src0_valid = 1'b0; src1_valid = 1'b0;

    // reset mid-frame aborts; next frame counts from zero
    do_reset();
    req = 2'b01;
    tick();
    src0_valid = 1'b1; src0_data = 8'h61;
    tick();
    src0_data = 8'h62;
    tick();
    rst_n = 1'b0;
    tick();
    check("s5_gnt", 16'(gnt), 16'h0);
    check("s5_valid", 16'(lcd_valid), 16'h0);
    check("s5_data", 16'(lcd_data), 16'h0);
    check("s5_busy", 16'(busy), 16'h0);
    check("s5_done", 16'(frame_done), 16'h0);
    check("s5_en0", 16'(src0_en), 16'h0);
    rst_n = 1'b1; src0_valid = 1'b0;
    tick();
    check("s5_regnt", 16'(gnt), 16'h1);
    for (int k = 0; k < 4; k++) begin
      src0_valid = 1'b1; src0_data = 8'(8'h71 + 8'(k));
      tick();
      check("s5_refr_done", 16'(frame_done), 16'(k == 3));
    end
    src0_valid = 1'b0;

    // granted source stalls
    do_reset();
    req = 2'b01;
    tick();
    src0_valid = 1'b1; src0_data = 8'h81;
    tick();
    src0_valid = 1'b0; req = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("s6_done", 16'(frame_done), 16'h0);
`ifdef LCD_ARB_TIMEOUT_EN
      check("s6_gnt", 16'(gnt), (k == 7) ? 16'h0 : 16'h1);
      check("s6_err", 16'(err_timeout), 16'(k == 7));
`else
      check("s6_gnt", 16'(gnt), 16'h1);
      check("s6_err", 16'(err_timeout), 16'h0);
`endif
    end
    check("s6_busy", 16'(busy), 16'h1);
    tick(); tick(); tick();
`ifdef LCD_ARB_TIMEOUT_EN
    check("s6_sticky", 16'(err_timeout), 16'h1);
    check("s6_idle", 16'(busy), 16'h0);
`else
    check("s6_hold", 16'(gnt), 16'h1);
`endif
    do_reset();
    check("s6_err_clr", 16'(err_timeout), 16'h0);
    check("s6_gnt_clr", 16'(gnt), 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
